// File: rtl/proc_pkg.sv
// Shared encodings for the multi-cycle core: instruction field positions,
// opcodes and FSM states.
package proc_pkg;

    localparam int RD_HI  = 15;
    localparam int RD_LO  = 12;
    localparam int OP_HI  = 11;
    localparam int OP_LO  = 8;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_OUTI  = 4'h1,
        OP_LOAD  = 4'h2,
        OP_LI    = 4'h3,
        OP_OUTR  = 4'h4,
        OP_STORE = 4'h5,
        OP_ADDI  = 4'h6,
        OP_JMP   = 4'h7,
        OP_BNZ   = 4'h8,
        OP_HALT  = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2,
        HALT  = 2'd3
    } state_e;

endpackage

// File: rtl/proc_regfile.sv
// Register file: one async read port, one write port, async clear,
// plus a dedicated tap on register 1 for debug.
module proc_regfile #(
    parameter  int NUM_REGS = 16,
    parameter  int DATA_W   = 8,
    localparam int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [SEL_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [SEL_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic [DATA_W-1:0] r1_o
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = regs_q[raddr_i];
    assign r1_o    = regs_q[1];

endmodule

// File: rtl/proc_core.sv
// Multi-cycle core: FETCH/EXEC/MEM/HALT sequencer, PC, instruction register,
// output register and the memory req/ack handshake.
module proc_core
    import proc_pkg::*;
#(
    parameter  int DATA_W   = 8,
    parameter  int ADDR_W   = 8,
    parameter  int NUM_REGS = 16,
    localparam int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [DATA_W-1:0] dbg_r1
);

    state_e              state_q;
    logic [15:0]         ir_q;
    logic [ADDR_W-1:0]   pc_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [15:0]         mem_wdata_q;
    logic [DATA_W-1:0]   out_q;
    logic                out_valid_q;
    logic                halted_q;

    opcode_e             op;
    logic [SEL_W-1:0]    rd_sel;
    logic [DATA_W-1:0]   imm_d;
    logic [ADDR_W-1:0]   imm_a;
    logic [DATA_W-1:0]   rd_val;
    logic [ADDR_W-1:0]   pc_d;
    logic                rf_we;
    logic [DATA_W-1:0]   rf_wdata;

    assign op     = opcode_e'(ir_q[OP_HI:OP_LO]);
    assign rd_sel = SEL_W'(ir_q[RD_HI:RD_LO]);
    assign imm_d  = DATA_W'(ir_q[IMM_HI:IMM_LO]);
    assign imm_a  = ADDR_W'(ir_q[IMM_HI:IMM_LO]);

    proc_regfile #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (rf_we),
        .waddr_i (rd_sel),
        .wdata_i (rf_wdata),
        .raddr_i (rd_sel),
        .rdata_o (rd_val),
        .r1_o    (dbg_r1)
    );

    always_comb begin
        pc_d = pc_q + ADDR_W'(1);
        if (op == OP_JMP || (op == OP_BNZ && rd_val != '0)) pc_d = imm_a;
    end

    // Register writes land on the edge that leaves EXEC, or the MEM ack edge for LOAD.
    always_comb begin
        rf_we    = 1'b0;
        rf_wdata = '0;
        if (state_q == EXEC) begin
            case (op)
                OP_LI:   begin rf_we = 1'b1; rf_wdata = imm_d;          end
                OP_ADDI: begin rf_we = 1'b1; rf_wdata = rd_val + imm_d; end
                default: ;
            endcase
        end else if (state_q == MEM && mem_ack && op == OP_LOAD) begin
            rf_we    = 1'b1;
            rf_wdata = DATA_W'(mem_rdata);
        end
    end

    // Bus outputs are registered with the state they belong to, so they hold
    // steady through wait states. FETCH with req low only occurs right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            ir_q        <= '0;
            pc_q        <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                FETCH: begin
                    if (!mem_req_q) begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= pc_q;
                    end else if (mem_ack) begin
                        ir_q      <= mem_rdata;
                        mem_req_q <= 1'b0;
                        state_q   <= EXEC;
                    end
                end
                EXEC: begin
                    case (op)
                        OP_OUTI: begin out_q <= imm_d;  out_valid_q <= 1'b1; end
                        OP_OUTR: begin out_q <= rd_val; out_valid_q <= 1'b1; end
                        default: ;
                    endcase
                    if (op == OP_HALT) begin
                        halted_q <= 1'b1;
                        state_q  <= HALT;
                    end else if (op == OP_LOAD || op == OP_STORE) begin
                        pc_q        <= pc_d;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= (op == OP_STORE);
                        mem_addr_q  <= imm_a;
                        mem_wdata_q <= (op == OP_STORE) ? 16'(rd_val) : 16'h0000;
                        state_q     <= MEM;
                    end else begin
                        pc_q       <= pc_d;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= pc_d;
                        state_q    <= FETCH;
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        mem_we_q    <= 1'b0;
                        mem_wdata_q <= '0;
                        mem_addr_q  <= pc_q;
                        state_q     <= FETCH;
                    end
                end
                HALT: ;
                default: state_q <= HALT;
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign pc        = pc_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_proc_core.sv
// Bench for proc_core: behavioural memory with wait states, output/write
// scoreboards, and a second instance at DATA_W=16, NUM_REGS=4.
module tb_proc_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req, mem_we, mem_ack, out_valid, halted;
    logic [7:0]  mem_addr, out, pc, dbg_r1;
    logic [15:0] mem_wdata, mem_rdata;

    logic        rst_b_n = 1'b0;
    logic        req_b, we_b, out_valid_b, halted_b;
    logic [7:0]  addr_b, pc_b;
    logic [15:0] wdata_b, rdata_b, out_b, dbg_r1_b;

    logic [15:0] mem  [256];
    logic [15:0] memb [256];
    int          wait_states = 0;
    int          wcnt = 0;
    logic        ack_hold = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_out[$], out_obs[$], fetch_obs[$];
    logic [15:0] exp_outb[$], outb_obs[$];
    logic [23:0] exp_wr[$], wr_obs[$];

    always #5 clk = ~clk;

    proc_core dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .out(out), .out_valid(out_valid), .pc(pc),
        .halted(halted), .dbg_r1(dbg_r1)
    );

    proc_core #(.DATA_W(16), .ADDR_W(8), .NUM_REGS(4)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .mem_req(req_b), .mem_we(we_b),
        .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_rdata(rdata_b),
        .mem_ack(req_b), .out(out_b), .out_valid(out_valid_b), .pc(pc_b),
        .halted(halted_b), .dbg_r1(dbg_r1_b)
    );

    assign mem_ack   = mem_req && !ack_hold && (wcnt >= wait_states);
    assign mem_rdata = mem[mem_addr];
    assign rdata_b   = memb[addr_b];

    always @(posedge clk) begin
        if (mem_req && !mem_ack) wcnt <= wcnt + 1;
        else                     wcnt <= 0;
    end

    // Monitor: commits writes and logs fetches/outputs at the quiet edge.
    always @(negedge clk) begin
        if (rst_n && mem_req && mem_ack) begin
            if (mem_we) begin
                mem[mem_addr] = mem_wdata;
                wr_obs.push_back({mem_addr, mem_wdata});
            end else begin
                fetch_obs.push_back(mem_addr);
            end
        end
        if (rst_n && out_valid) out_obs.push_back(out);
        if (rst_b_n && req_b && we_b) memb[addr_b] = wdata_b;
        if (rst_b_n && out_valid_b) outb_obs.push_back(out_b);
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        out_obs.delete(); fetch_obs.delete(); wr_obs.delete();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++; if (mem_req !== 1'b0)   begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
        checks++; if (mem_we !== 1'b0)    begin errors++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
        checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_mem_addr got %h exp 00", mem_addr); end
        checks++; if (mem_wdata !== 16'h0) begin errors++; $display("FAIL reset_mem_wdata got %h exp 0000", mem_wdata); end
        checks++; if (out !== 8'h00)      begin errors++; $display("FAIL reset_out got %h exp 00", out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (pc !== 8'h00)       begin errors++; $display("FAIL reset_pc got %h exp 00", pc); end
        checks++; if (halted !== 1'b0)    begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
        checks++; if (dbg_r1 !== 8'h00)   begin errors++; $display("FAIL reset_dbg_r1 got %h exp 00", dbg_r1); end
    endtask

    task automatic test_out_halt();
        int k = -1, t_valid = -1, n_valid = 0, t_halt = -1, req_after = 0;
        logic [7:0] e, g;
        clear_mem();
        mem[0] = 16'h13AB; mem[1] = 16'h1400; mem[2] = 16'h0F00;
        wait_states = 0;
        exp_out.push_back(8'hAB);
        apply_reset();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (k < 0 && mem_req) k = 0;
            else if (k >= 0) k++;
            if (out_valid) begin n_valid++; t_valid = k; end
            if (t_halt >= 0 && mem_req) req_after++;
            if (halted && t_halt < 0) t_halt = k;
        end
        checks++; if (n_valid != 1)  begin errors++; $display("FAIL oh_pulse_count got %0d exp 1", n_valid); end
        checks++; if (t_valid != 4)  begin errors++; $display("FAIL oh_pulse_cycle got %0d exp 4", t_valid); end
        checks++; if (t_halt != 6)   begin errors++; $display("FAIL oh_halt_cycle got %0d exp 6", t_halt); end
        checks++; if (req_after != 0) begin errors++; $display("FAIL oh_req_after_halt got %0d exp 0", req_after); end
        checks++; if (dbg_r1 !== 8'hAB) begin errors++; $display("FAIL oh_dbg_r1 got %h exp ab", dbg_r1); end
        checks++; if (out !== 8'hAB) begin errors++; $display("FAIL oh_out_hold got %h exp ab", out); end
        while (exp_out.size() > 0) begin
            e = exp_out.pop_front();
            checks++;
            if (out_obs.size() == 0) begin errors++; $display("FAIL oh_out_sb got none exp %h", e); end
            else begin
                g = out_obs.pop_front();
                if (g !== e) begin errors++; $display("FAIL oh_out_sb got %h exp %h", g, e); end
            end
        end
    endtask

    task automatic test_load_store_waits();
        int unstable = 0;
        logic       prev_wait = 1'b0;
        logic [7:0] pa;
        logic       pw;
        logic [15:0] pd;
        logic [23:0] e, g;
        bit done = 0;
        clear_mem();
        mem[0] = 16'h2220; mem[1] = 16'h26FF; mem[2] = 16'h2521; mem[3] = 16'h0F00;
        mem[8'h20] = 16'h1234;
        wait_states = 3;
        exp_wr.push_back({8'h21, 16'h0033});
        apply_reset();
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (prev_wait && (mem_addr !== pa || mem_we !== pw || mem_wdata !== pd || !mem_req)) unstable++;
            prev_wait = mem_req && !mem_ack;
            pa = mem_addr; pw = mem_we; pd = mem_wdata;
            done = halted;
        end
        wait_states = 0;
        checks++; if (!done) begin errors++; $display("FAIL ls_timeout halted got 0 exp 1"); end
        checks++; if (unstable != 0) begin errors++; $display("FAIL ls_bus_stable got %0d changes exp 0", unstable); end
        checks++; if (mem[8'h21] !== 16'h0033) begin errors++; $display("FAIL ls_mem21 got %h exp 0033", mem[8'h21]); end
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            checks++;
            if (wr_obs.size() == 0) begin errors++; $display("FAIL ls_wr_sb got none exp %h", e); end
            else begin
                g = wr_obs.pop_front();
                if (g !== e) begin errors++; $display("FAIL ls_wr_sb got %h exp %h", g, e); end
            end
        end
        checks++; if (wr_obs.size() != 0) begin errors++; $display("FAIL ls_extra_writes got %0d exp 0", wr_obs.size()); end
    endtask

    task automatic test_countdown();
        int n_bnz = 0, n_body = 0;
        bit done = 0;
        logic [7:0] e, g;
        clear_mem();
        mem[0] = 16'h3303; mem[1] = 16'h36FF; mem[2] = 16'h3801;
        mem[3] = 16'h0155; mem[4] = 16'h0F00;
        exp_out.push_back(8'h55);
        apply_reset();
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            done = halted;
        end
        foreach (fetch_obs[i]) begin
            if (fetch_obs[i] == 8'h02) n_bnz++;
            if (fetch_obs[i] == 8'h01) n_body++;
        end
        checks++; if (!done) begin errors++; $display("FAIL cd_timeout halted got 0 exp 1"); end
        checks++; if (n_bnz != 3) begin errors++; $display("FAIL cd_bnz_evals got %0d exp 3", n_bnz); end
        checks++; if (n_body - 1 != 2) begin errors++; $display("FAIL cd_bnz_taken got %0d exp 2", n_body - 1); end
        while (exp_out.size() > 0) begin
            e = exp_out.pop_front();
            checks++;
            if (out_obs.size() == 0) begin errors++; $display("FAIL cd_out_sb got none exp %h", e); end
            else begin
                g = out_obs.pop_front();
                if (g !== e) begin errors++; $display("FAIL cd_out_sb got %h exp %h", g, e); end
            end
        end
    endtask

    task automatic test_pc_wrap();
        bit done = 0, armed = 0;
        int bad = -1;
        clear_mem();
        apply_reset();
        for (int c = 0; c < 800 && !done; c++) begin
            @(negedge clk);
            // HALT appears at 0x02 only once the PC has wrapped past 0xFF.
            if (!armed && fetch_obs.size() > 0 && fetch_obs[$] == 8'hFF) begin
                mem[2] = 16'h0F00;
                armed = 1;
            end
            done = halted;
        end
        for (int i = 0; i < fetch_obs.size() && bad < 0; i++)
            if (fetch_obs[i] !== 8'(i % 256)) bad = i;
        checks++; if (!done) begin errors++; $display("FAIL wrap_timeout halted got 0 exp 1"); end
        checks++; if (fetch_obs.size() != 259) begin errors++; $display("FAIL wrap_fetch_count got %0d exp 259", fetch_obs.size()); end
        checks++; if (bad >= 0) begin errors++; $display("FAIL wrap_seq index %0d got %h exp %h", bad, fetch_obs[bad], 8'(bad % 256)); end
        checks++; if (pc !== 8'h02) begin errors++; $display("FAIL wrap_final_pc got %h exp 02", pc); end
    endtask

    task automatic test_reset_mid_load();
        bit found = 0;
        clear_mem();
        mem[0] = 16'h135A; mem[1] = 16'h0177; mem[2] = 16'h1220; mem[8'h20] = 16'h00CC;
        apply_reset();
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (mem_req && !mem_we && mem_addr == 8'h20) begin ack_hold = 1'b1; found = 1; end
        end
        repeat (3) @(negedge clk);
        checks++; if (!found) begin errors++; $display("FAIL rm_reach_mem got 0 exp 1"); end
        checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h20) begin errors++; $display("FAIL rm_held_req got req=%b addr=%h exp 1/20", mem_req, mem_addr); end
        checks++; if (dbg_r1 !== 8'h5A || out !== 8'h77 || pc !== 8'h03) begin errors++; $display("FAIL rm_pre_state got r1=%h out=%h pc=%h exp 5a/77/03", dbg_r1, out, pc); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || mem_addr !== 8'h00) begin errors++; $display("FAIL rm_async_req got req=%b addr=%h exp 0/00", mem_req, mem_addr); end
        checks++; if (pc !== 8'h00 || out !== 8'h00) begin errors++; $display("FAIL rm_async_pc_out got pc=%h out=%h exp 00/00", pc, out); end
        checks++; if (dbg_r1 !== 8'h00) begin errors++; $display("FAIL rm_async_regs got %h exp 00", dbg_r1); end
        ack_hold = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h00 || mem_we !== 1'b0) begin errors++; $display("FAIL rm_restart got req=%b addr=%h we=%b exp 1/00/0", mem_req, mem_addr, mem_we); end
    endtask

    task automatic test_param_sweep();
        bit done = 0;
        logic [15:0] e, g;
        for (int i = 0; i < 256; i++) memb[i] = 16'h0000;
        memb[0] = 16'h5307; memb[1] = 16'h2210; memb[2] = 16'h2400; memb[3] = 16'h0F00;
        memb[8'h10] = 16'hBEEF;
        exp_outb.push_back(16'hBEEF);
        rst_b_n = 1'b0;
        repeat (2) @(negedge clk);
        outb_obs.delete();
        rst_b_n = 1'b1;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            done = halted_b;
        end
        checks++; if (!done) begin errors++; $display("FAIL sw_timeout halted got 0 exp 1"); end
        checks++; if (dbg_r1_b !== 16'h0007) begin errors++; $display("FAIL sw_r5_aliases_r1 got %h exp 0007", dbg_r1_b); end
        while (exp_outb.size() > 0) begin
            e = exp_outb.pop_front();
            checks++;
            if (outb_obs.size() == 0) begin errors++; $display("FAIL sw_out_sb got none exp %h", e); end
            else begin
                g = outb_obs.pop_front();
                if (g !== e) begin errors++; $display("FAIL sw_out_sb got %h exp %h", g, e); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_out_halt();
        test_load_store_waits();
        test_countdown();
        test_pc_wrap();
        test_reset_mid_load();
        test_param_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/proc_core.md
# proc_core

Parametrised multi-cycle processor core: the successor to the single-cycle demo core. It fetches 16-bit instructions from an external word-addressed memory over a req/ack handshake, and executes them against a reset-cleared register file. It adds stores, immediate add, jumps, a conditional branch and halt. It sits between the memory model/arbiter and the top-level debug/output logic.

## Interface
- `DATA_W`, 8: register/ALU width; legal range 8..16.
- `ADDR_W`, 8: memory word-address and PC width; legal range 8..16.
- `NUM_REGS`, 16: register count; power of two, 2..16.
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `mem_req` out 1: memory request; reset 0.
- `mem_we` out 1: 1 = write; reset 0.
- `mem_addr` out ADDR_W: word address; reset 0.
- `mem_wdata` out 16: write data, zero-extended register value; reset 0.
- `mem_rdata` in 16: read data, valid when `mem_ack`=1.
- `mem_ack` in 1: completes the current request.
- `out` out DATA_W: output register; reset 0.
- `out_valid` out 1: one-cycle pulse when `out` is written; reset 0.
- `pc` out ADDR_W: current PC; reset 0.
- `halted` out 1: core stopped; reset 0.
- `dbg_r1` out DATA_W: live copy of register 1; reset 0.

## Operation
- Instruction fields: [15:12] register `rd`, [11:8] opcode, [7:0] `imm`.
- `imm` is zero-extended to DATA_W or ADDR_W. Register selects ≥ NUM_REGS use the low log2(NUM_REGS) bits.
- Opcodes:
  - 0 NOP.
  - 1 OUTI: `out`=imm.
  - 2 LOAD: rd = mem[imm][DATA_W-1:0].
  - 3 LI: rd = imm.
  - 4 OUTR: `out` = rd.
  - 5 STORE: mem[imm] = rd.
  - 6 ADDI: rd = rd + imm, wrapping mod 2^DATA_W.
  - 7 JMP: pc = imm.
  - 8 BNZ: if rd ≠ 0 then pc = imm.
  - F HALT.
  - 9..E: execute as NOP.
- `out` holds its value between OUT instructions; it is not cleared each cycle.
- All registers reset to 0.
- FSM states:
  - FETCH: `mem_req`=1, `mem_we`=0, `mem_addr`=pc. On ack, latch the instruction and go to EXEC.
  - EXEC: decode and execute. LOAD/STORE go to MEM. HALT goes to HALT. Everything else goes to FETCH.
  - MEM: `mem_req`=1, `mem_addr`=imm, `mem_we`=1 for STORE. On ack, complete the operation and go to FETCH.
  - HALT: absorbing; `mem_req`=0, `halted`=1. Left only by reset.
- PC update in EXEC: pc+1, wrapping mod 2^ADDR_W, unless a JMP or a taken BNZ loads imm.

## Timing
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are decoded from the registered state only. They are stable while `mem_req`=1 until ack is sampled.
- `mem_ack` may rise in the same cycle as `mem_req` (zero-wait memory).
- `mem_ack` sampled while `mem_req`=0 is ignored.
- With zero-wait memory:
  - Non-memory instructions take 2 cycles.
  - LOAD and STORE take 3 cycles.
  - Each wait cycle adds one cycle.
- `out`/`out_valid` and register writes become visible the cycle after EXEC. For LOAD they become visible the cycle after the MEM ack.
- `mem_req` drops in the cycle after ack unless the next state also requests. FETCH after MEM is back-to-back, so `mem_req` stays high with the new address.
- Reset asserted mid-transaction: all outputs return to reset values immediately (asynchronously). The memory must tolerate an abandoned request.
- On reset release, FETCH starts at pc=0 on the first clock edge.

## Structure
- Package `proc_pkg`:
  - `opcode_e` (4-bit enum).
  - `state_e` (FETCH, EXEC, MEM, HALT).
  - Field position constants: RD_HI/LO, OP_HI/LO, IMM_HI/LO.
- Sub-module `proc_regfile`:
  - Parameters NUM_REGS and DATA_W.
  - One asynchronous read port, one write port.
  - Asynchronous active-low clear.
  - Dedicated `r1` output.
- The core holds the FSM, PC, instruction register, `out` and the handshake logic.

## Test plan
- Zero-wait memory with program `LI r1,0xAB; OUTR r1; HALT`:
  - `out`=0xAB with one `out_valid` pulse at cycle 4.
  - `dbg_r1`=0xAB.
  - `halted`=1 at cycle 6; `mem_req` stays 0 afterwards.
- mem[0x20]=0x1234, program `LOAD r2,0x20; ADDI r2,0xFF; STORE r2,0x21`, memory inserting 3 wait states:
  - mem[0x21]=0x0033 (0x34+0xFF wraps).
  - `mem_addr`/`mem_we` stable throughout every wait.
- Countdown loop `LI r3,3; ADDI r3,0xFF; BNZ r3,1; OUTI 0x55; HALT`:
  - Exactly 3 BNZ evaluations, 2 of them taken.
  - `out`=0x55.
- PC wrap with ADDR_W=8: memory filled with NOP and HALT at address 0x02, start from reset → pc sequence 0..0xFF, 0x00, 0x01, 0x02, then halt.
- Reset mid-load (`rst_n` low while in MEM with ack withheld):
  - `mem_req`, `pc`, `out` and all registers read 0 immediately.
  - Restart fetches address 0.
- Parameter sweep DATA_W=16, NUM_REGS=4: `LI r5,7` writes r1; `LOAD` returns the full 16-bit word.
